// File: rtl/fa_sweep_driver.sv
// Full-adder initiator: sweeps all 8 {a,b,c} vectors PASSES times and checks sum/carry against a reference.
// Each vector takes SETTLE_CYCLES+2 cycles; start is only sampled in IDLE, and every output is registered.
module fa_sweep_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic [2:0]       vec_idx,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       LAST_PASS   = 8'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    logic [2:0]       state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [2:0]       abc_q, abc_d;
    logic [7:0]       pass_q, pass_d;
    logic [3:0]       settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fail_q, fail_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mismatch;

    // The registered drive bits are the reference, so the check sees exactly what the responder saw.
    assign mismatch = (sum != ^abc_q) ||
                      (carry != ((abc_q[2] & abc_q[1]) | (abc_q[2] & abc_q[0]) | (abc_q[1] & abc_q[0])));

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        abc_d    = abc_q;
        pass_d   = pass_q;
        settle_d = settle_q;
        err_d    = err_q;
        fail_d   = fail_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = '0;
                    fail_d  = 1'b0;
                    vec_d   = 3'd0;
                    abc_d   = 3'd0;
                    pass_d  = 8'd0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                settle_d = SETTLE_LOAD;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (settle_q == 4'd0) state_d  = S_CHECK;
                else                  settle_d = settle_q - 4'd1;
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                    fail_d = 1'b1;
                end
                if (vec_q != 3'd7) begin
                    vec_d   = vec_q + 3'd1;
                    abc_d   = vec_q + 3'd1;
                    state_d = S_DRIVE;
                end else if (pass_q != LAST_PASS) begin
                    pass_d  = pass_q + 8'd1;
                    vec_d   = 3'd0;
                    abc_d   = 3'd0;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                abc_d   = 3'd0;
                vec_d   = 3'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= 3'd0;
            abc_q    <= 3'd0;
            pass_q   <= 8'd0;
            settle_q <= 4'd0;
            err_q    <= '0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            abc_q    <= abc_d;
            pass_q   <= pass_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign a       = abc_q[2];
    assign b       = abc_q[1];
    assign c       = abc_q[0];
    assign vec_idx = vec_q;
    assign err_cnt = err_q;
    assign fail    = fail_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_fa_sweep_driver.sv
// Bench for fa_sweep_driver: a faultable full-adder responder, a cycle-indexed timing model and a scenario table.
module tb_fa_sweep_driver;
    localparam int S     = 2;
    localparam int P     = 2;
    localparam int EW    = 4;
    localparam int VPER  = S + 2;
    localparam int SWEEP = 8 * P * VPER;
    localparam int EMAX  = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          a, b, c, sum, carry, busy, done, fail;
    logic [2:0]    vec_idx;
    logic [EW-1:0] err_cnt;

    int            mode = 0;
    logic [7:0]    mask = 8'h00;
    int            n_vec = 0;
    int            n_bad = 0;

    fa_sweep_driver #(.SETTLE_CYCLES(S), .PASSES(P), .ERR_W(EW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
        .sum(sum), .carry(carry), .busy(busy), .done(done),
        .vec_idx(vec_idx), .err_cnt(err_cnt), .fail(fail)
    );

    always #5 clk = ~clk;

    // Responder: ideal adder with injectable faults (1 sum stuck-0, 2 carry inverted, 3 sum flipped on mask).
    always_comb begin
        sum   = a ^ b ^ c;
        carry = (a & b) | (a & c) | (b & c);
        if (mode == 1) sum = 1'b0;
        if (mode == 2) carry = ~carry;
        if (mode == 3 && mask[{a, b, c}]) sum = ~sum;
    end

    typedef struct {
        int   mode;
        logic [7:0] mask;
        bit   hold;
        int   fin_err;
        bit   fin_fail;
    } sc_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit vec_bad(input int v);
        int ones;
        ones = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
        case (mode)
            1:       return (ones % 2) == 1;
            2:       return 1'b1;
            3:       return mask[v];
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_err(input int n_checked);
        int cnt = 0;
        for (int g = 0; g < n_checked; g++) if (vec_bad(g % 8)) cnt++;
        return (cnt > EMAX) ? EMAX : cnt;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_abc"}, {a, b, c}, 3'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check_idle(tag);
        check({tag, "_vec"}, vec_idx, 3'd0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_fail"}, fail, 1'b0);
    endtask

    // Cycle k counts from the edge that samples start (edge 0); outputs are sampled at the falling edge.
    task automatic run_sweep(input bit hold, input int rst_at, input int fin_err, input bit fin_fail);
        int n, ev, e;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= SWEEP + 1; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            n = (k - 1) / VPER;
            e = model_err(n);
            if (k <= SWEEP) begin
                ev = n % 8;
                check("abc", {a, b, c}, ev);
                check("vec_idx", vec_idx, ev);
                check("busy", busy, 1'b1);
                check("done", done, 1'b0);
            end else begin
                check("abc_done", {a, b, c}, 3'd7);
                check("busy_done", busy, 1'b0);
                check("done_pulse", done, 1'b1);
                check("fin_err", err_cnt, fin_err);
                check("fin_fail", fail, fin_fail);
            end
            check("err_cnt", err_cnt, e);
            check("fail", fail, e > 0);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check_reset("midrst");
                @(negedge clk); rst = 1'b0; start = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check_idle("after_done");
        check("hold_err", err_cnt, fin_err);
        check("hold_fail", fail, fin_fail);
        @(negedge clk);
        if (hold) begin
            check("restart_busy", busy, 1'b1);
            check("restart_err", err_cnt, 0);
            check("restart_fail", fail, 1'b0);
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk); rst = 1'b0;
        end else begin
            check_idle("stay_idle");
            check("stay_err", err_cnt, fin_err);
        end
    endtask

    initial begin
        sc_t tbl[8];
        tbl[0] = '{0, 8'h00, 1'b0, 0, 1'b0};
        tbl[1] = '{1, 8'h00, 1'b0, 8, 1'b1};
        tbl[2] = '{2, 8'h00, 1'b0, 15, 1'b1};
        tbl[3] = '{2, 8'h00, 1'b1, 15, 1'b1};
        tbl[4] = '{0, 8'h00, 1'b1, 0, 1'b0};
        for (int i = 5; i < 8; i++) tbl[i] = '{3, 8'($urandom), 1'b0, -1, 1'b0};

        #2 rst = 1'b1;
        #1 check_reset("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("post_reset");

        for (int i = 0; i < 8; i++) begin
            int fe;
            mode = tbl[i].mode;
            mask = tbl[i].mask;
            fe = (tbl[i].fin_err >= 0) ? tbl[i].fin_err : model_err(8 * P);
            run_sweep(tbl[i].hold, 0, fe, fe > 0);
        end

        // Reset while vector 3 is in its first WAIT cycle, then a clean sweep must follow.
        mode = 2;
        run_sweep(1'b0, 1 + 3 * VPER + 1, 0, 1'b0);
        mode = 0;
        run_sweep(1'b0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
